store_hex: RTL and testbench
============================

Name: store_hex

Overview:
- Password-entry register for the keypad lock datapath.
- Captures one 4-bit hex digit per `enter` press and shifts it into a 16-bit password word, first digit ending up in the most-significant nibble.
- Sits between the keypad/hex decoder (which drives `hex_in` and `enter`) and the password compare/unlock logic (which reads `password` and `full`).

Parameters:
- NUM_DIGITS, 4, number of hex digits stored; `password` width = 4*NUM_DIGITS.
- DIGIT_W, 4, bits per digit. Fixed at 4; other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. 0 clears all state immediately; the block runs while it is 1.
- hex_in  input  4  digit to store; must be stable from the `enter` rise until capture (3 clk edges).
- enter  input  1  asynchronous level from the button/debouncer; each 0->1 transition requests one digit capture.
- password  output  16  stored digits; the oldest digit sits in [15:12] once 4 are entered.
- digit_count  output  3  number of digits captured since reset, range 0..4.
- full  output  1  high when digit_count == NUM_DIGITS.

Behaviour:
- Reset (reset == 0, asynchronous assert): `password`=16'h0000, `digit_count`=0, `full`=0, and both synchronizer flops and the edge-detect flop are 0. Release is synchronous: the flops sample normally from the first rising clk after reset returns to 1.
- `enter` passes through a 2-flop synchronizer (s1, s2) and then a delay flop (s3).
- A capture pulse is `s2 & ~s3`, exactly one clk cycle wide per 0->1 transition of `enter`.
- Holding `enter` high produces a single capture. Glitches shorter than a clk period may be missed; `enter` is specified as debounced upstream.
- Latency: `enter` rises before clk edge k. s1 goes high at k, s2 at k+1, the capture pulse is active during cycle k+1..k+2, and the capture takes effect at edge k+2. `password` and `digit_count` show the new value after edge k+2.
- On capture with `digit_count` < NUM_DIGITS:
  - `password` <= {password[11:0], hex_in}, i.e. shift left by 4 and insert the new digit in the low nibble;
  - `digit_count` increments by 1.
- On capture with `full` = 1: ignored. `password` and `digit_count` hold; the entry is locked until reset. There is no wrap-around and no overwrite.
- `full` is registered together with `digit_count`, so it rises on the same edge as the 4th capture.
- `hex_in` is sampled only at the capture edge; its value at other times is don't-care.
- Reset asserted mid-sequence (any count, including while a capture is in the synchronizer) discards the partial entry and the pending capture. The next `enter` after release starts from an empty register.
- If `enter` rises at the same time reset releases, the press is either captured or dropped; it is never captured twice.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: drive reset=0 with `enter` toggling -> `password`=0000, `digit_count`=0, `full`=0 for the whole assertion.
- Basic entry: after reset, enter digits C, F, 0, 3 (hex_in held, enter pulsed high for 3+ clks, then low) -> `password` goes 000C, 00CF, 0CF0, CF03; `digit_count` 1..4; `full`=1 after the 4th.
- Latency/single capture: raise `enter` and hold it high 20 clks with hex_in=A -> exactly one capture, visible after the 3rd rising clk edge; `digit_count`=1, `password`=000A.
- Overflow: with password=CF03 and full=1, pulse `enter` with hex_in=5 -> `password` stays CF03, `digit_count` stays 4.
- Mid-entry reset: enter 1, 2, assert reset for a partial cycle (asynchronously), release, then enter 7 -> `password`=0007, `digit_count`=1.
- Don't-care input: change hex_in freely while `enter` is low -> no change to `password` or `digit_count`.

Source files
------------

// File: rtl/store_hex.sv
// Keypad password register: synchronizes the enter button, turns each rising edge
// into one capture pulse and shifts hex digits in MSB-first until NUM_DIGITS are held.
module store_hex #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W-1:0]            hex_in,
  input  logic                          enter,
  output logic [NUM_DIGITS*DIGIT_W-1:0] password,
  output logic [2:0]                    digit_count,
  output logic                          full
);

  localparam int              PW_W      = NUM_DIGITS * DIGIT_W;
  localparam logic [2:0]      LAST_SLOT = 3'(NUM_DIGITS - 1);

  logic            s1_q, s2_q, s3_q;
  logic [PW_W-1:0] pw_q, pw_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            capture_s;

  // One-cycle pulse per synchronized 0->1 transition of enter.
  assign capture_s = s2_q & ~s3_q;

  // Next-state: shift in a digit on capture unless the entry is already locked.
  always_comb begin
    pw_d   = pw_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (capture_s && !full_q) begin
      pw_d   = {pw_q[PW_W-DIGIT_W-1:0], hex_in};
      cnt_d  = cnt_q + 3'd1;
      full_d = (cnt_q == LAST_SLOT);
    end else begin
      pw_d   = pw_q;
      cnt_d  = cnt_q;
      full_d = full_q;
    end
  end

  // Synchronizer, edge-detect delay flop and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      pw_q   <= '0;
      cnt_q  <= 3'd0;
      full_q <= 1'b0;
    end else begin
      s1_q   <= enter;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      pw_q   <= pw_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign password    = pw_q;
  assign digit_count = cnt_q;
  assign full        = full_q;

endmodule

// File: tb/tb_store_hex.sv
// Self-checking bench for store_hex: directed scenarios plus randomized press
// sequences compared against a digit-list model of the password entry.
module tb_store_hex;

  logic        clk;
  logic        reset;
  logic [3:0]  hex_in;
  logic        enter;
  logic [15:0] password;
  logic [2:0]  digit_count;
  logic        full;

  int checks_cnt;
  int errors_cnt;

  logic [3:0] digits[$];

  store_hex #(.NUM_DIGITS(4), .DIGIT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .hex_in      (hex_in),
    .enter       (enter),
    .password    (password),
    .digit_count (digit_count),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Password is the accepted digits read as a base-16 number, oldest digit first.
  function automatic logic [15:0] model_pw();
    logic [15:0] pw;
    pw = 16'h0000;
    foreach (digits[i]) pw = (pw << 4) | 16'(digits[i]);
    return pw;
  endfunction

  function automatic void model_accept(input logic [3:0] d);
    if (digits.size() < 4) digits.push_back(d);
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_pw"},   32'(password),    32'(model_pw()));
    check_eq({tag, "_cnt"},  32'(digit_count), 32'(digits.size()));
    check_eq({tag, "_full"}, 32'(full),        32'(digits.size() == 4));
  endtask

  // One button press: rise at a falling edge, hold, release, and let the capture settle.
  task automatic press(input logic [3:0] d, input int hold);
    int low;
    @(negedge clk);
    hex_in = d;
    enter  = 1'b1;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    low = (hold >= 3) ? 1 : (3 - hold);
    low += int'($urandom_range(0, 2));
    repeat (low) @(negedge clk);
    model_accept(d);
    hex_in = 4'($urandom);
  endtask

  task automatic sync_reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    digits.delete();
    @(negedge clk);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset  = 1'b0;
    enter  = 1'b0;
    hex_in = 4'h0;

    // Reset held while enter toggles: everything stays cleared.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      enter = ~enter;
      check_state("reset_hold");
    end
    enter = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_state("after_release");

    // Basic entry C, F, 0, 3.
    press(4'hC, 3); check_eq("basic1_pw", 32'(password), 32'h000C); check_state("basic1");
    press(4'hF, 4); check_eq("basic2_pw", 32'(password), 32'h00CF); check_state("basic2");
    press(4'h0, 3); check_eq("basic3_pw", 32'(password), 32'h0CF0); check_state("basic3");
    press(4'h3, 5); check_eq("basic4_pw", 32'(password), 32'hCF03); check_state("basic4");
    check_eq("basic4_full", 32'(full), 32'd1);

    // Overflow: further presses are ignored.
    press(4'h5, 3); check_eq("ovf_pw", 32'(password), 32'hCF03); check_state("ovf");
    press(4'h9, 1); check_state("ovf2");

    // Latency and single capture with enter held for 20 clocks.
    sync_reset_pulse();
    check_state("lat_clear");
    hex_in = 4'hA;
    enter  = 1'b1;
    @(posedge clk); #1 check_eq("lat_edge_k",   32'(digit_count), 32'd0);
    @(posedge clk); #1 check_eq("lat_edge_k1",  32'(digit_count), 32'd0);
    @(posedge clk); #1 check_eq("lat_edge_k2",  32'(digit_count), 32'd1);
    check_eq("lat_edge_k2_pw", 32'(password), 32'h000A);
    repeat (17) @(posedge clk);
    #1 check_eq("lat_hold_cnt", 32'(digit_count), 32'd1);
    @(negedge clk);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    digits.push_back(4'hA);
    check_state("lat_done");

    // Mid-entry asynchronous reset, then a fresh entry.
    sync_reset_pulse();
    press(4'h1, 3);
    press(4'h2, 3);
    check_state("mid_pre");
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_eq("mid_async_cnt", 32'(digit_count), 32'd0);
    check_eq("mid_async_pw", 32'(password), 32'h0000);
    #2 reset = 1'b1;
    digits.delete();
    press(4'h7, 3);
    check_eq("mid_new_pw", 32'(password), 32'h0007);
    check_state("mid_new");

    // Reset while a capture is still in the synchronizer drops it.
    @(negedge clk);
    hex_in = 4'h9;
    enter  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_eq("pend_async_cnt", 32'(digit_count), 32'd0);
    enter = 1'b0;
    #1 reset = 1'b1;
    digits.delete();
    repeat (4) @(negedge clk);
    check_state("pend_dropped");

    // hex_in changes while enter is low have no effect.
    press(4'h4, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hex_in = 4'($urandom);
    end
    check_state("dontcare");

    // Randomized rounds of presses with random digits and hold times.
    for (int r = 0; r < 8; r++) begin
      int n;
      sync_reset_pulse();
      check_state("rnd_clear");
      n = int'($urandom_range(0, 6));
      for (int p = 0; p < n; p++) begin
        press(4'($urandom), int'($urandom_range(1, 5)));
        check_state("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
